data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Data-side memory slave directly downstream of the core's load/store unit: accepts its
//  req/gnt/rvalid bus requests and serves word reads and byte-enabled writes from on-chip RAM.
//  Programmable wait states model slow memory, so LSU stall/handshake paths get exercised.
//  Sits between the LSU data port and the RAM; one request outstanding at a time.
// PARAMETERS
//  WORD_SIZE    32    data/address width in bits
//  DEPTH        1024  number of WORD_SIZE words stored
//  WAIT_CYCLES  0     cycles req must be held before gnt (0 = grant in the same cycle)
// PORTS
//  clk           in   1          clock, all state on rising edge
//  rst           in   1          reset, synchronous, active-high
//  data_req_i    in   1          request valid from LSU
//  data_addr_i   in   WORD_SIZE  byte address; bits [1:0] ignored
//  data_we_i     in   1          1 = write, 0 = read
//  data_be_i     in   4          byte enables, write only
//  data_wdata_i  in   WORD_SIZE  write data
//  data_gnt_o    out  1          request accepted this cycle
//  data_rvalid_o out  1          response valid, one cycle wide
//  data_rdata_o  out  WORD_SIZE  read data, valid with rvalid
//  data_err_o    out  1          out-of-range access, only with DATA_MEM_ERR_EN
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset values: gnt=0, rvalid=0, rdata=0, err=0, wait counter=0, FSM=IDLE.
//    RAM contents are not reset.
//  - FSM states:
//    IDLE: req=1 and WAIT_CYCLES=0 -> gnt=1 combinationally; stay IDLE.
//          req=1 and WAIT_CYCLES>0 -> go to WAIT, cnt=1.
//    WAIT: req=1 -> cnt++; when cnt==WAIT_CYCLES, gnt=1 and return to IDLE.
//          req=0 -> abort, cnt=0, go to IDLE; no access and no response.
//  - Access at gnt edge, word index = addr[log2(DEPTH)+1:2].
//    Write: bytes with be[i]=1 are updated.
//    Read: word registered into rdata.
//  - rvalid=1 exactly one cycle after each gnt, for reads and writes; no response stall.
//    rdata is held until the next read response; write responses leave rdata unchanged.
//  - Back-to-back: with WAIT_CYCLES=0, one gnt and one rvalid per cycle.
//    A response and a new gnt may occur in the same cycle.
//    Read-after-write to the same word returns the new data.
//  - Attributes (addr, we, be, wdata) are sampled only in the gnt cycle;
//    changes during WAIT are not checked.
//  - Write with be=0: gnt and rvalid are issued; RAM is unchanged.
//  - rst asserted mid-wait or mid-response: the pending gnt/rvalid is dropped.
//    The following cycle shows reset values.
// CONFIGURATION
//  DATA_MEM_ERR_EN defined:
//    - Any address >= DEPTH*4 is still granted, with rvalid and err=1 one cycle later.
//    - rdata=0 for reads and the RAM is not written. err has the same timing as rvalid.
//  DATA_MEM_ERR_EN undefined:
//    - Address wraps modulo DEPTH*4.
//    - data_err_o is tied to 0 and there is no range compare.
// STRUCTURE
//  - data_mem_pkg holds:
//    - the FSM enum (IDLE, WAIT)
//    - a function computing the wait-counter width as $clog2(WAIT_CYCLES+1)
//    - the localparam BE_WIDTH = WORD_SIZE/8
//  - Sub-module data_mem_ram: DEPTH x WORD_SIZE single-port synchronous RAM with byte-write.
//    data_mem_ctrl owns the FSM, counter and response registers.
// TESTING
//  1. WAIT_CYCLES=0, write 0xDEADBEEF to 0x10 (be=F), then read 0x10
//     -> gnt in the req cycles, rvalid one cycle later each time, rdata=0xDEADBEEF.
//  2. Partial write be=0b0010, wdata=0x0000AB00 over 0x11223344
//     -> read returns 0x1122AB44.
//  3. WAIT_CYCLES=3, read held
//     -> gnt in the 4th req cycle, rvalid in the 5th.
//     Same setup with req dropped after 2 cycles -> no gnt, no rvalid, FSM back in IDLE.
//  4. Back-to-back: 4 reads on consecutive cycles (WAIT_CYCLES=0)
//     -> 4 consecutive rvalid pulses with the correct data, in order.
//  5. rst raised in the cycle after gnt -> rvalid stays 0; all outputs at reset values.
//  6. DATA_MEM_ERR_EN, DEPTH=1024: write then read at 0x1000
//     -> err=1 with each rvalid, rdata=0, word 0 untouched.
//     Without the macro: the same read returns word 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM type, byte-lane count and wait-counter sizing for data_mem_ctrl
package data_mem_pkg;
   localparam int WORD_BITS = 32;
   localparam int BE_WIDTH = WORD_BITS / 8;
   typedef enum logic {IDLE, WAIT} state_t;
   function automatic int cnt_width(input int wait_cycles);
      return wait_cycles > 0 ? $clog2(wait_cycles + 1) : 1;
   endfunction
endpackage

// File: rtl/data_mem_ram.sv
// data_mem_ram: single-port synchronous RAM with byte writes; read word held until the next read
module data_mem_ram
   import data_mem_pkg::*;
#(
   parameter int WORD_SIZE = WORD_BITS,
   parameter int DEPTH = 1024,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic                 we,
   input  logic [BE_WIDTH-1:0]  be,
   input  logic [AW-1:0]        addr,
   input  logic [WORD_SIZE-1:0] wdata,
   output logic [WORD_SIZE-1:0] rdata
);
   logic [WORD_SIZE-1:0] mem [DEPTH];
   // byte-lane write on enabled writes, registered read on enabled reads
   always_ff @(posedge clk) begin
      if (en && we)
         for (int i = 0; i < BE_WIDTH; i++)
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      if (en && !we) rdata <= mem[addr];
   end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: LSU req/gnt/rvalid slave with programmable wait states; optional range error via DATA_MEM_ERR_EN
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int WORD_SIZE = WORD_BITS,
   parameter int DEPTH = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 data_req_i,
   input  logic [WORD_SIZE-1:0] data_addr_i,
   input  logic                 data_we_i,
   input  logic [BE_WIDTH-1:0]  data_be_i,
   input  logic [WORD_SIZE-1:0] data_wdata_i,
   output logic                 data_gnt_o,
   output logic                 data_rvalid_o,
   output logic [WORD_SIZE-1:0] data_rdata_o,
   output logic                 data_err_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_width(WAIT_CYCLES);
   state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic gnt, rvalid, zero, oor, unused_addr;
   logic [WORD_SIZE-1:0] q;
`ifdef DATA_MEM_ERR_EN
   logic err;
   assign oor = data_addr_i >= WORD_SIZE'(DEPTH * 4);
   assign unused_addr = ^data_addr_i[1:0];
   // error flag travels with the response of an out-of-range access
   always_ff @(posedge clk)
      if (rst) err <= 1'b0;
      else err <= gnt && oor;
   assign data_err_o = err && !rst;
`else
   assign oor = 1'b0;
   assign unused_addr = ^{data_addr_i[WORD_SIZE-1:AW+2], data_addr_i[1:0]};
   assign data_err_o = 1'b0;
`endif
   // wait-state sequencing: grant once req has been held WAIT_CYCLES cycles, abort on req drop
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      gnt = 1'b0;
      if (state == IDLE) begin
         if (data_req_i && WAIT_CYCLES == 0) gnt = 1'b1;
         else if (data_req_i) begin
            state_nxt = WAIT;
            cnt_nxt = CW'(1);
         end
      end else if (!data_req_i) begin
         state_nxt = IDLE;
         cnt_nxt = '0;
      end else if (cnt == CW'(WAIT_CYCLES)) begin
         gnt = 1'b1;
         state_nxt = IDLE;
         cnt_nxt = '0;
      end else cnt_nxt = cnt + 1'b1;
      if (rst) gnt = 1'b0;
   end
   // FSM, counter and response registers; zero forces rdata to 0 after reset or an errored read
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         rvalid <= 1'b0;
         zero <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         rvalid <= gnt;
         if (gnt && !data_we_i) zero <= oor;
      end
   data_mem_ram #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH)) u_ram (
      .clk(clk),
      .en(gnt && !oor),
      .we(data_we_i),
      .be(data_be_i),
      .addr(data_addr_i[AW+1:2]),
      .wdata(data_wdata_i),
      .rdata(q)
   );
   assign data_gnt_o = gnt;
   assign data_rvalid_o = rvalid && !rst;
   assign data_rdata_o = zero ? '0 : q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: two controllers (0 and 3 wait states) on shared stimulus, checked against a bench model
module tb_data_mem_ctrl;
`ifdef DATA_MEM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0] be = '0;
   logic gnt_v [2], rv_v [2], er_v [2];
   logic [31:0] rd_v [2];
   int n_chk = 0, n_fail = 0;
   int run [2] = '{0, 0};
   bit pend [2] = '{0, 0}, perr [2] = '{0, 0}, mrd_known [2] = '{0, 0};
   logic [31:0] mrd [2];
   logic [31:0] mem [2][1024];
   bit known [2][1024];
   bit m_eg, m_oor;
   int m_idx;
   always #5 clk = ~clk;
   data_mem_ctrl #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
      .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt_v[0]), .data_rvalid_o(rv_v[0]),
      .data_rdata_o(rd_v[0]), .data_err_o(er_v[0]));
   data_mem_ctrl #(.WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
      .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt_v[1]), .data_rvalid_o(rv_v[1]),
      .data_rdata_o(rd_v[1]), .data_err_o(er_v[1]));
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   // model: a request is granted in its (W+1)-th consecutive req cycle; response one cycle later
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         m_eg = !rst && req && run[k] == (k == 0 ? 0 : 3);
         chk($sformatf("m_gnt%0d", k), {31'b0, gnt_v[k]}, {31'b0, m_eg});
         chk($sformatf("m_rvalid%0d", k), {31'b0, rv_v[k]}, {31'b0, !rst && pend[k]});
         chk($sformatf("m_err%0d", k), {31'b0, er_v[k]}, {31'b0, !rst && pend[k] && perr[k]});
         if (!rst && mrd_known[k]) chk($sformatf("m_rdata%0d", k), rd_v[k], mrd[k]);
         if (rst) begin
            run[k] = 0;
            pend[k] = 0;
            perr[k] = 0;
            mrd[k] = '0;
            mrd_known[k] = 1;
         end else begin
            pend[k] = m_eg;
            perr[k] = 0;
            run[k] = (req && !m_eg) ? run[k] + 1 : 0;
            if (m_eg) begin
               m_oor = ERR_EN && addr >= 32'h1000;
               m_idx = int'(addr[11:2]);
               perr[k] = m_oor;
               if (we && !m_oor) begin
                  for (int b = 0; b < 4; b++)
                     if (be[b]) mem[k][m_idx][8*b +: 8] = wdata[8*b +: 8];
                  known[k][m_idx] = known[k][m_idx] || be == 4'hF;
               end
               if (!we) begin
                  mrd[k] = m_oor ? 32'h0 : mem[k][m_idx];
                  mrd_known[k] = m_oor || known[k][m_idx];
               end
            end
         end
      end
   end
   task automatic cyc(input bit r_s, input bit r, input bit w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d);
      @(posedge clk);
      #1;
      rst = r_s;
      req = r;
      we = w;
      addr = a;
      be = b;
      wdata = d;
      @(negedge clk);
   endtask
   task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
      cyc(0, 1, 1, a, b, d);
   endtask
   task automatic rd(input logic [31:0] a);
      cyc(0, 1, 0, a, 4'h0, 32'h0);
   endtask
   task automatic idle();
      cyc(0, 0, 0, 32'h0, 4'h0, 32'h0);
   endtask
   initial begin
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
      chk("rst_gnt", {31'b0, gnt_v[0]}, 0);
      chk("rst_rvalid", {31'b0, rv_v[0]}, 0);
      chk("rst_rdata0", rd_v[0], 0);
      chk("rst_rdata3", rd_v[1], 0);
      chk("rst_err", {31'b0, er_v[0]}, 0);
      wr(32'h10, 4'hF, 32'hDEADBEEF);
      chk("t1_wgnt", {31'b0, gnt_v[0]}, 1);
      rd(32'h10);
      chk("t1_rgnt", {31'b0, gnt_v[0]}, 1);
      chk("t1_wresp", {31'b0, rv_v[0]}, 1);
      chk("t1_wresp_rdata", rd_v[0], 0);
      idle();
      chk("t1_rresp", {31'b0, rv_v[0]}, 1);
      chk("t1_rdata", rd_v[0], 32'hDEADBEEF);
      idle();
      chk("t1_one_pulse", {31'b0, rv_v[0]}, 0);
      wr(32'h20, 4'hF, 32'h11223344);
      wr(32'h20, 4'b0010, 32'h0000AB00);
      rd(32'h20);
      idle();
      chk("t2_partial", rd_v[0], 32'h1122AB44);
      wr(32'h20, 4'h0, 32'hFFFFFFFF);
      chk("t2_be0_gnt", {31'b0, gnt_v[0]}, 1);
      rd(32'h20);
      chk("t2_be0_resp", {31'b0, rv_v[0]}, 1);
      idle();
      chk("t2_be0_data", rd_v[0], 32'h1122AB44);
      for (int i = 0; i < 4; i++) begin
         wr(32'h30, 4'hF, 32'hCAFEF00D);
         chk($sformatf("t3_wgnt%0d", i), {31'b0, gnt_v[1]}, {31'b0, i == 3});
      end
      for (int i = 0; i < 4; i++) begin
         rd(32'h30);
         chk($sformatf("t3_rgnt%0d", i), {31'b0, gnt_v[1]}, {31'b0, i == 3});
      end
      idle();
      chk("t3_rresp", {31'b0, rv_v[1]}, 1);
      chk("t3_rdata", rd_v[1], 32'hCAFEF00D);
      rd(32'h30);
      rd(32'h30);
      idle();
      chk("t3_abort_gnt", {31'b0, gnt_v[1]}, 0);
      chk("t3_abort_rv", {31'b0, rv_v[1]}, 0);
      idle();
      chk("t3_abort_rv2", {31'b0, rv_v[1]}, 0);
      for (int i = 0; i < 4; i++) begin
         rd(32'h30);
         chk($sformatf("t3_regnt%0d", i), {31'b0, gnt_v[1]}, {31'b0, i == 3});
      end
      idle();
      chk("t3_reresp", {31'b0, rv_v[1]}, 1);
      for (int i = 0; i < 4; i++) wr(32'h40 + 4 * i, 4'hF, 32'hA0000000 + i);
      for (int i = 0; i < 4; i++) begin
         rd(32'h40 + 4 * i);
         chk($sformatf("t4_rv%0d", i), {31'b0, rv_v[0]}, 1);
         if (i > 0) chk($sformatf("t4_rd%0d", i - 1), rd_v[0], 32'hA0000000 + i - 1);
      end
      idle();
      chk("t4_rv_last", {31'b0, rv_v[0]}, 1);
      chk("t4_rd3", rd_v[0], 32'hA0000003);
      rd(32'h10);
      chk("t5_gnt", {31'b0, gnt_v[0]}, 1);
      cyc(1, 1, 0, 32'h10, 4'h0, 32'h0);
      chk("t5_rv_dropped", {31'b0, rv_v[0]}, 0);
      chk("t5_gnt_rst", {31'b0, gnt_v[0]}, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("t5_rdata", rd_v[0], 0);
      chk("t5_rv", {31'b0, rv_v[0]}, 0);
      chk("t5_err", {31'b0, er_v[0]}, 0);
      idle();
      chk("t5_after", {31'b0, rv_v[0]}, 0);
      wr(32'h0, 4'hF, 32'h5A5A5A5A);
      wr(32'h1000, 4'hF, 32'hFFFFFFFF);
      rd(32'h1000);
      chk("t6_wresp", {31'b0, rv_v[0]}, 1);
      chk("t6_werr", {31'b0, er_v[0]}, {31'b0, ERR_EN});
      idle();
      chk("t6_rresp", {31'b0, rv_v[0]}, 1);
      chk("t6_rerr", {31'b0, er_v[0]}, {31'b0, ERR_EN});
      chk("t6_rdata", rd_v[0], ERR_EN ? 32'h0 : 32'hFFFFFFFF);
      rd(32'h0);
      idle();
      chk("t6_word0", rd_v[0], ERR_EN ? 32'h5A5A5A5A : 32'hFFFFFFFF);
      chk("t6_word0_err", {31'b0, er_v[0]}, 0);
      idle();
      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
